// File: rtl/spi_tx_wr_arbiter_if.sv
// Write-side bundle between the packet sources, the SPI transmit BRAM
// buffer and the arbiter that sequences bytes into it.
interface spi_tx_wr_arbiter_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 11,
    parameter int LENWIDTH  = 8
);
    logic                 req_a;
    logic [LENWIDTH-1:0]  len_a;
    logic [DATAWIDTH-1:0] data_a;
    logic                 ack_a;
    logic                 req_b;
    logic [LENWIDTH-1:0]  len_b;
    logic [DATAWIDTH-1:0] data_b;
    logic                 ack_b;
    logic                 rd_pulse;
    logic                 wen0;
    logic [DATAWIDTH-1:0] wdata0;
    logic [ADDRWIDTH-1:0] waddr0;
    logic [1:0]           grant;
    logic [ADDRWIDTH-1:0] level;
    logic                 full;

    // arbiter side
    modport slave (
        input  req_a, len_a, data_a, req_b, len_b, data_b, rd_pulse,
        output ack_a, ack_b, wen0, wdata0, waddr0, grant, level, full
    );

    // sources / buffer side
    modport master (
        output req_a, len_a, data_a, req_b, len_b, data_b, rd_pulse,
        input  ack_a, ack_b, wen0, wdata0, waddr0, grant, level, full
    );
endinterface

// File: rtl/spi_tx_wr_arbiter.sv
// Round-robin arbiter of two byte-stream requesters onto the SPI transmit
// buffer write port. Each byte takes a 4-cycle slot (CHECK, WR1, WR2, GAP);
// the buffer commits on the second consecutive wen0 cycle (WR2). Occupancy
// is tracked from rd_pulse and writes stall in CHECK while the buffer is full.
module spi_tx_wr_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 11,
    parameter int LENWIDTH  = 8
) (
    input  logic              clka0,
    input  logic              rstn,
    spi_tx_wr_arbiter_if.slave bus
);
    // One slot is always left empty so write and read pointers never collide.
    localparam logic [ADDRWIDTH-1:0] LEVEL_MAX = {ADDRWIDTH{1'b1}};

    typedef enum logic [2:0] {IDLE, CHECK, WR1, WR2, GAP} state_t;

    state_t               state, state_nxt;
    logic                 owner_b;     // current packet owner: 0=A, 1=B
    logic                 rr_last_b;   // last packet finished by B
    logic [1:0]           grant_r;
    logic [LENWIDTH-1:0]  remaining;
    logic [LENWIDTH-1:0]  len_sel;
    logic [DATAWIDTH-1:0] wdata_r;
    logic [ADDRWIDTH-1:0] waddr_r;
    logic [ADDRWIDTH-1:0] level_r;
    logic                 full_w;
    logic                 pick_b;
    logic                 commit;
    logic                 take_rd;
    logic                 wen_w;

    assign full_w  = (level_r == LEVEL_MAX);
    // B wins when it is alone, or when both request and A went last.
    assign pick_b  = bus.req_b && (!bus.req_a || !rr_last_b);
    assign len_sel = pick_b ? bus.len_b : bus.len_a;
    assign commit  = (state == WR2);
    // A read pulse on an empty buffer is spurious and is dropped.
    assign take_rd = bus.rd_pulse && (level_r != '0);

    // State register.
    always_ff @(posedge clka0 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and write-enable decode; wen0 is a pure state decode so it
    // falls asynchronously with rstn and an interrupted write never commits.
    always_comb begin
        state_nxt = state;
        wen_w     = 1'b0;
        case (state)
            IDLE:  if (bus.req_a || bus.req_b) state_nxt = CHECK;
            CHECK: if (!full_w) state_nxt = WR1;
            WR1: begin
                wen_w     = 1'b1;
                state_nxt = WR2;
            end
            WR2: begin
                wen_w     = 1'b1;
                state_nxt = GAP;
            end
            GAP:     state_nxt = (remaining == '0) ? IDLE : CHECK;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, packet length, data latch and write pointer.
    always_ff @(posedge clka0 or negedge rstn) begin
        if (!rstn) begin
            owner_b   <= 1'b0;
            rr_last_b <= 1'b1;
            grant_r   <= 2'b00;
            remaining <= '0;
            wdata_r   <= '0;
            waddr_r   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_a || bus.req_b) begin
                    owner_b   <= pick_b;
                    grant_r   <= pick_b ? 2'b10 : 2'b01;
                    // A zero length is treated as a single-byte packet.
                    remaining <= (len_sel == '0) ? LENWIDTH'(1) : len_sel;
                end
                CHECK: if (!full_w) wdata_r <= owner_b ? bus.data_b : bus.data_a;
                WR2: begin
                    waddr_r   <= waddr_r + ADDRWIDTH'(1);
                    remaining <= remaining - LENWIDTH'(1);
                end
                GAP: if (remaining == '0) begin
                    rr_last_b <= owner_b;
                    grant_r   <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    // Occupancy: +1 per commit, -1 per accepted read, unchanged when both.
    always_ff @(posedge clka0 or negedge rstn) begin
        if (!rstn)                    level_r <= '0;
        else if (commit && !take_rd)  level_r <= level_r + ADDRWIDTH'(1);
        else if (!commit && take_rd)  level_r <= level_r - ADDRWIDTH'(1);
    end

    assign bus.wen0   = wen_w;
    assign bus.wdata0 = wdata_r;
    assign bus.waddr0 = waddr_r;
    assign bus.grant  = grant_r;
    assign bus.ack_a  = commit && !owner_b;
    assign bus.ack_b  = commit && owner_b;
    assign bus.level  = level_r;
    assign bus.full   = full_w;
endmodule

// File: tb/tb_spi_tx_wr_arbiter.sv
// Bench for spi_tx_wr_arbiter with a 16-entry buffer. A per-cycle monitor
// reconstructs commits from the wen0 contract and checks them against
// per-requester byte queues, expected addresses and an occupancy count.
module tb_spi_tx_wr_arbiter;
    localparam int DW = 8, AW = 4, LW = 8;

    logic clka0 = 1'b0;
    logic rstn  = 1'b0;
    always #5 clka0 = ~clka0;

    spi_tx_wr_arbiter_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LENWIDTH(LW)) bus ();
    spi_tx_wr_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LENWIDTH(LW)) dut (
        .clka0(clka0), .rstn(rstn), .bus(bus)
    );

    int n_chk = 0, n_fail = 0, ncyc = 0, n_commit = 0;
    int err_lvl = 0, err_data = 0, err_ack = 0, err_stab = 0, err_intl = 0;
    logic [7:0] src_a[$], src_b[$];
    int left_a = 0, left_b = 0;
    bit busy_a = 0, busy_b = 0;
    int lvl_m = 0;
    logic [3:0] exp_addr = 4'd1;
    logic wen_prev = 1'b0;
    logic [3:0] addr_prev = '0;
    logic [7:0] data_prev = '0;
    logic [1:0] last_owner = 2'b00;
    logic [3:0] cwaddr[$];
    logic [1:0] cown[$];
    logic [7:0] cdat[$];
    int ack_cyc_a[$];

    task automatic clear_logs();
        cwaddr.delete(); cown.delete(); cdat.delete(); ack_cyc_a.delete();
    endtask

    task automatic clear_model();
        bus.req_a = 0; bus.req_b = 0; bus.rd_pulse = 0;
        src_a.delete(); src_b.delete();
        left_a = 0; left_b = 0; busy_a = 0; busy_b = 0;
        lvl_m = 0; exp_addr = 4'd1; wen_prev = 0; last_owner = 2'b00;
    endtask

    // One clock: sample at negedge, update the model, drive rd_pulse.
    // mode: 0 no reads, 1 read every cycle, 2 random reads, 3 read on commit.
    task automatic cyc(input int mode);
        logic commit, rd;
        @(negedge clka0);
        ncyc++;
        commit = bus.wen0 && wen_prev && rstn;
        if (bus.wen0 && wen_prev && (bus.waddr0 !== addr_prev || bus.wdata0 !== data_prev)) err_stab++;
        if (bus.ack_a !== (commit && bus.grant == 2'b01)) err_ack++;
        if (bus.ack_b !== (commit && bus.grant == 2'b10)) err_ack++;
        if (bus.level !== 4'(lvl_m) || bus.full !== (lvl_m == 15)) err_lvl++;
        if (bus.ack_a) ack_cyc_a.push_back(ncyc);
        if (commit) begin
            n_commit++;
            if (lvl_m == 15) err_lvl++;
            cwaddr.push_back(bus.waddr0); cown.push_back(bus.grant); cdat.push_back(bus.wdata0);
            if (bus.waddr0 + 4'd1 !== exp_addr) err_data++;
            exp_addr = exp_addr + 4'd1;
            if (last_owner == 2'b01 && bus.grant != 2'b01 && busy_a) err_intl++;
            if (last_owner == 2'b10 && bus.grant != 2'b10 && busy_b) err_intl++;
            if (bus.grant == 2'b01) begin
                if (src_a.size() == 0 || bus.wdata0 !== src_a[0]) err_data++;
                if (src_a.size() != 0) void'(src_a.pop_front());
                left_a--; busy_a = (left_a > 0);
                if (left_a <= 0) bus.req_a = 0;
                bus.data_a = (src_a.size() != 0) ? src_a[0] : 8'($urandom);
            end else if (bus.grant == 2'b10) begin
                if (src_b.size() == 0 || bus.wdata0 !== src_b[0]) err_data++;
                if (src_b.size() != 0) void'(src_b.pop_front());
                left_b--; busy_b = (left_b > 0);
                if (left_b <= 0) bus.req_b = 0;
                bus.data_b = (src_b.size() != 0) ? src_b[0] : 8'($urandom);
            end else err_data++;
            last_owner = bus.grant;
        end
        case (mode)
            1:       rd = 1'b1;
            2:       rd = ($urandom_range(0, 3) == 0);
            3:       rd = commit;
            default: rd = 1'b0;
        endcase
        lvl_m = lvl_m + int'(commit) - ((rd && lvl_m > 0) ? 1 : 0);
        wen_prev  = bus.wen0 && rstn;
        addr_prev = bus.waddr0;
        data_prev = bus.wdata0;
        bus.rd_pulse = rd;
    endtask

    // Start a packet: bytes first, first+step, ...; a zero length carries one byte.
    task automatic issue(input bit is_b, input int len, input logic [7:0] first, input logic [7:0] step);
        int eff;
        eff = (len == 0) ? 1 : len;
        for (int i = 0; i < eff; i++) begin
            if (is_b) src_b.push_back(8'(first + i * step));
            else      src_a.push_back(8'(first + i * step));
        end
        if (is_b) begin left_b = eff; bus.len_b = 8'(len); bus.data_b = src_b[0]; bus.req_b = 1; end
        else      begin left_a = eff; bus.len_a = 8'(len); bus.data_a = src_a[0]; bus.req_a = 1; end
    endtask

    task automatic run_until_idle(input int mode, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            cyc(mode);
            ok = (left_a <= 0 && left_b <= 0 && bus.grant == 2'b00);
        end
    endtask

    task automatic do_reset();
        @(negedge clka0);
        rstn = 0;
        clear_model();
        bus.len_a = 0; bus.len_b = 0; bus.data_a = 0; bus.data_b = 0;
        repeat (2) @(negedge clka0);
        rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0);
        n_chk++; if (bus.wen0 !== 1'b0 || bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0) begin n_fail++; $display("FAIL reset_ctl wen0=%b ack=%b%b want 0", bus.wen0, bus.ack_a, bus.ack_b); end
        n_chk++; if (bus.wdata0 !== 8'h00 || bus.waddr0 !== 4'h0) begin n_fail++; $display("FAIL reset_bus wdata0=%h waddr0=%h want 0", bus.wdata0, bus.waddr0); end
        n_chk++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", bus.grant); end
        n_chk++; if (bus.level !== 4'h0 || bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_level level=%0d full=%b want 0/0", bus.level, bus.full); end
    endtask

    task automatic test_single_a();
        int k; bit ok; int e0;
        e0 = err_data + err_ack + err_stab + err_lvl;
        clear_logs();
        issue(0, 3, 8'h11, 8'h11);
        k = ncyc;
        cyc(0);
        n_chk++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b want 01", bus.grant); end
        run_until_idle(0, 60, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout left_a=%0d", left_a); end
        n_chk++; if (cdat.size() != 3 || cdat[0] !== 8'h11 || cdat[1] !== 8'h22 || cdat[2] !== 8'h33) begin n_fail++; $display("FAIL single_data n=%0d want 11,22,33", cdat.size()); end
        n_chk++; if (cwaddr.size() != 3 || cwaddr[0] !== 4'd0 || cwaddr[1] !== 4'd1 || cwaddr[2] !== 4'd2) begin n_fail++; $display("FAIL single_addr n=%0d want waddr0 0,1,2", cwaddr.size()); end
        n_chk++; if (ack_cyc_a.size() != 3 || ack_cyc_a[0] != k + 3 || ack_cyc_a[1] != k + 7 || ack_cyc_a[2] != k + 11) begin n_fail++; $display("FAIL single_ack_timing n=%0d first=%0d want %0d step 4", ack_cyc_a.size(), (ack_cyc_a.size() != 0) ? ack_cyc_a[0] - k : -1, 3); end
        n_chk++; if (bus.grant !== 2'b00 || bus.level !== 4'd3) begin n_fail++; $display("FAIL single_end grant=%b level=%0d want 00/3", bus.grant, bus.level); end
        n_chk++; if (err_data + err_ack + err_stab + err_lvl != e0) begin n_fail++; $display("FAIL single_monitor errors=%0d want %0d", err_data + err_ack + err_stab + err_lvl, e0); end
    endtask

    task automatic test_rr();
        logic [1:0] exp_own[$]; logic [1:0] f; bit rr_b; bit ok; int mism;
        do_reset();
        clear_logs();
        rr_b = 1;
        issue(0, 2, 8'h40, 8'h01); issue(1, 2, 8'h80, 8'h01);
        f = rr_b ? 2'b01 : 2'b10;
        repeat (2) exp_own.push_back(f); repeat (2) exp_own.push_back(~f);
        rr_b = (f == 2'b01);
        run_until_idle(1, 80, ok);
        issue(0, 1, 8'h50, 8'h01);
        exp_own.push_back(2'b01); rr_b = 0;
        run_until_idle(1, 80, ok);
        issue(0, 2, 8'h60, 8'h01); issue(1, 2, 8'h90, 8'h01);
        f = rr_b ? 2'b01 : 2'b10;
        repeat (2) exp_own.push_back(f); repeat (2) exp_own.push_back(~f);
        run_until_idle(1, 80, ok);
        n_chk++; if (!ok || cown.size() != exp_own.size()) begin n_fail++; $display("FAIL rr_count got %0d commits want %0d", cown.size(), exp_own.size()); end
        mism = 0;
        for (int i = 0; i < cown.size() && i < exp_own.size(); i++) if (cown[i] !== exp_own[i]) mism++;
        n_chk++; if (mism != 0) begin n_fail++; $display("FAIL rr_order %0d owners differ, first got %b want %b", mism, (cown.size() != 0) ? cown[0] : 2'bxx, exp_own[0]); end
        n_chk++; if (err_intl != 0 || err_data != 0) begin n_fail++; $display("FAIL rr_stream interleave=%0d data=%0d want 0", err_intl, err_data); end
    endtask

    task automatic test_full();
        int c0, wen_hi, cwin; bit ok;
        do_reset();
        c0 = n_commit;
        issue(0, 16, 8'h01, 8'h01);
        for (int i = 0; i < 200 && n_commit - c0 < 15; i++) cyc(0);
        wen_hi = 0; cwin = n_commit;
        for (int i = 0; i < 12; i++) begin cyc(0); if (bus.wen0) wen_hi++; end
        n_chk++; if (bus.full !== 1'b1 || bus.level !== 4'd15) begin n_fail++; $display("FAIL full_set full=%b level=%0d want 1/15", bus.full, bus.level); end
        n_chk++; if (wen_hi != 0 || n_commit != cwin || n_commit - c0 != 15) begin n_fail++; $display("FAIL full_stall wen_hi=%0d commits=%0d want 0 and 15", wen_hi, n_commit - c0); end
        cyc(1);
        cyc(0);
        n_chk++; if (bus.level !== 4'd14 || bus.full !== 1'b0) begin n_fail++; $display("FAIL full_read level=%0d full=%b want 14/0", bus.level, bus.full); end
        run_until_idle(0, 60, ok);
        n_chk++; if (!ok || n_commit - c0 != 16 || bus.full !== 1'b1) begin n_fail++; $display("FAIL full_resume commits=%0d full=%b want 16/1", n_commit - c0, bus.full); end
        repeat (20) cyc(1);
        n_chk++; if (bus.level !== 4'd0 || err_lvl != 0) begin n_fail++; $display("FAIL full_drain level=%0d level_errors=%0d want 0/0", bus.level, err_lvl); end
    endtask

    task automatic test_level_edges();
        bit ok;
        do_reset();
        issue(1, 5, 8'hC0, 8'h03);
        run_until_idle(0, 60, ok);
        n_chk++; if (bus.level !== 4'd5) begin n_fail++; $display("FAIL level_fill got %0d want 5", bus.level); end
        issue(1, 1, 8'hD7, 8'h00);
        run_until_idle(3, 40, ok);
        n_chk++; if (!ok || bus.level !== 4'd5) begin n_fail++; $display("FAIL level_coincide got %0d want 5", bus.level); end
        repeat (10) cyc(1);
        cyc(1);
        cyc(0);
        n_chk++; if (bus.level !== 4'd0 || err_lvl != 0) begin n_fail++; $display("FAIL level_underflow got %0d want 0", bus.level); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        issue(0, 14, 8'h20, 8'h05);
        run_until_idle(1, 120, ok);
        n_chk++; if (bus.waddr0 !== 4'd14) begin n_fail++; $display("FAIL wrap_start waddr0=%0d want 14", bus.waddr0); end
        clear_logs();
        issue(0, 3, 8'hE1, 8'h01);
        run_until_idle(1, 40, ok);
        n_chk++; if (cwaddr.size() != 3 || cwaddr[0] !== 4'd14 || cwaddr[1] !== 4'd15 || cwaddr[2] !== 4'd0) begin n_fail++; $display("FAIL wrap_seq n=%0d want waddr0 14,15,0", cwaddr.size()); end
        n_chk++; if (bus.waddr0 !== 4'd1 || err_data != 0) begin n_fail++; $display("FAIL wrap_end waddr0=%0d data_errors=%0d want 1/0", bus.waddr0, err_data); end
    endtask

    task automatic test_random();
        bit ok; int c0;
        c0 = n_commit;
        for (int i = 0; i < 600; i++) begin
            if (!bus.req_a && $urandom_range(0, 2) == 0) issue(0, $urandom_range(0, 5), 8'($urandom), 8'($urandom_range(1, 255)));
            if (!bus.req_b && $urandom_range(0, 2) == 0) issue(1, $urandom_range(0, 5), 8'($urandom), 8'($urandom_range(1, 255)));
            cyc(2);
        end
        run_until_idle(2, 400, ok);
        n_chk++; if (!ok || src_a.size() != 0 || src_b.size() != 0) begin n_fail++; $display("FAIL rand_drain left a=%0d b=%0d", src_a.size(), src_b.size()); end
        n_chk++; if (n_commit - c0 < 20) begin n_fail++; $display("FAIL rand_progress commits=%0d want >=20", n_commit - c0); end
        n_chk++; if (err_data != 0 || err_intl != 0) begin n_fail++; $display("FAIL rand_stream data=%0d interleave=%0d want 0", err_data, err_intl); end
        n_chk++; if (err_lvl != 0) begin n_fail++; $display("FAIL rand_level errors=%0d want 0", err_lvl); end
        n_chk++; if (err_ack != 0 || err_stab != 0) begin n_fail++; $display("FAIL rand_protocol ack=%0d stability=%0d want 0", err_ack, err_stab); end
    endtask

    task automatic test_reset_mid();
        bit prev, hit, ok; int c0;
        prev = 0; hit = 0;
        issue(0, 4, 8'hA0, 8'h01);
        for (int i = 0; i < 30 && !hit; i++) begin
            cyc(0);
            if (bus.wen0 && !prev) hit = 1;
            prev = bus.wen0;
        end
        n_chk++; if (!hit) begin n_fail++; $display("FAIL rstmid_wr1 not reached"); end
        c0 = n_commit;
        #2 rstn = 0;
        #1;
        n_chk++; if (bus.wen0 !== 1'b0 || bus.grant !== 2'b00 || bus.ack_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_async wen0=%b grant=%b ack_a=%b want 0", bus.wen0, bus.grant, bus.ack_a); end
        n_chk++; if (bus.waddr0 !== 4'd0 || bus.wdata0 !== 8'h00 || bus.level !== 4'd0 || bus.full !== 1'b0) begin n_fail++; $display("FAIL rstmid_regs waddr0=%0d wdata0=%h level=%0d full=%b want 0", bus.waddr0, bus.wdata0, bus.level, bus.full); end
        clear_model();
        repeat (2) cyc(0);
        rstn = 1;
        cyc(0);
        n_chk++; if (n_commit != c0 || bus.waddr0 !== 4'd0) begin n_fail++; $display("FAIL rstmid_nocommit commits=%0d waddr0=%0d want 0/0", n_commit - c0, bus.waddr0); end
        clear_logs();
        issue(1, 1, 8'h5B, 8'h00); issue(0, 1, 8'h5A, 8'h00);
        run_until_idle(0, 40, ok);
        n_chk++; if (!ok || cown.size() != 2 || cown[0] !== 2'b01 || cwaddr[0] !== 4'd0) begin n_fail++; $display("FAIL rstmid_rr n=%0d first owner=%b want 01", cown.size(), (cown.size() != 0) ? cown[0] : 2'bxx); end
    endtask

    initial begin
        bus.req_a = 0; bus.req_b = 0; bus.rd_pulse = 0;
        bus.len_a = 0; bus.len_b = 0; bus.data_a = 0; bus.data_b = 0;
        test_reset();
        test_single_a();
        test_rr();
        test_full();
        test_level_edges();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
